signed_seg_display: RTL
=======================

// Module: signed_seg_display
// PURPOSE
//  Successor to the fixed 8-bit sign-digit encoder. Accepts a WIDTH-bit two's-complement value over a valid/ready handshake.
//  Converts the magnitude to BCD with a sequential double-dabble engine.
//  Drives a time-multiplexed, active-low 7-segment display of DIGITS positions. The leftmost position is the sign digit.
//  Sits between the adder datapath and the board display pins.
// PARAMETERS
//  WIDTH          8      input value width, two's complement (>=2)
//  DIGITS         4      display positions incl. sign; DIGITS-1 magnitude digits (>=2)
//  REFRESH_DIV    50000  clk cycles each position is lit (>=1)
//  BLANK_LEADING  1      1: blank leading zero digits; 0: show them
// PORTS
//  clk       in   1       system clock, single domain
//  rst       in   1       synchronous, active-high reset
//  in_value  in   WIDTH   signed value to display
//  in_valid  in   1       in_value valid
//  in_ready  out  1       block can accept a value (IDLE only)
//  busy      out  1       conversion in progress
//  overflow  out  1       displayed magnitude >= 10^(DIGITS-1)
//  seg       out  8       {dp,a,b,c,d,e,f,g}, active low; seg[0]=g
//  an        out  DIGITS  position enables, active low, one-hot; an[0]=rightmost
// BEHAVIOUR
//  Reset values (cycle after rst high):
//   - state IDLE, in_ready=1, busy=0, overflow=0.
//   - seg=8'hFF, an=all 1s, display register = +0.
//   - prescaler=0, scan index=0.
//  FSM IDLE -> CONV -> LOAD -> IDLE:
//   - IDLE: on in_valid&&in_ready, latch sign=in_value[WIDTH-1] and magnitude=|in_value| as unsigned WIDTH bits.
//     -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
//     Latch ovf=(magnitude>=10^(DIGITS-1)). Go to CONV.
//   - CONV: exactly WIDTH cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, bringing in the magnitude MSB.
//     BCD accumulator is 4*(DIGITS-1) bits; bits shifted out are discarded (covered by ovf).
//   - LOAD: 1 cycle; copy sign, BCD and ovf into the display register; go to IDLE.
//   - Latency: display register holds the new value WIDTH+2 cycles after the handshake cycle.
//     in_ready=1 only in IDLE; busy=1 in CONV and LOAD.
//   - The previous value stays displayed during conversion. in_valid outside IDLE is ignored.
//  Scan:
//   - Prescaler counts 0..REFRESH_DIV-1 and wraps.
//   - On its terminal count the scan index advances 0,1,..,DIGITS-1,0.
//  Output register (seg/an updated every cycle from current index and display register):
//   - an = ~(1<<index).
//   - index DIGITS-1 (sign): 8'hFE if sign=1, else 8'hFF.
//   - magnitude digits with overflow=1: 8'hFE (dash).
//   - otherwise decode 0..9 -> 81,CF,92,86,CC,A4,A0,8F,80,84 (hex).
//   - BLANK_LEADING=1: zero digits above the most significant nonzero digit -> 8'hFF. Digit 0 is always shown.
//  overflow output mirrors the display register flag.
//  Edge cases:
//   - LOAD coincident with a scan tick: both occur; seg reflects new data from the next cycle.
//   - rst mid-conversion: conversion aborts, all registers take reset values.
//   - Input zero: sign=0, shown as "0".
// TESTING (WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless stated)
//  1. rst 2 cycles, release -> seg=FF, an=F, in_ready=1.
//     an then steps E,D,B,7,E, each held 4 cycles.
//  2. in_value=8'h7B (123) -> in_ready low 9 cycles.
//     Positions 2,1,0 = CF,92,86; sign=FF; overflow=0.
//  3. in_value=8'h80 (-128) -> sign=FE; positions 2,1,0 = CF,92,80.
//  4. in_value=8'h05 -> positions 2,1=FF, 0=A4.
//     in_value=8'h00 -> position 0=81, sign=FF.
//     BLANK_LEADING=0 with 8'h05 -> 81,81,A4.
//  5. WIDTH=12, DIGITS=4, in_value=12'h3E8 (1000) -> overflow=1; positions 2..0=FE; sign=FF.
//     12'hC18 (-1000) -> sign=FE.
//  6. Accept 8'h9C (-100), assert rst at CONV cycle 3 -> in_ready=1, overflow=0.
//     Display shows +0; the value is never displayed.

Source files
------------

// File: rtl/signed_seg_display.sv
// Signed value to multiplexed active-low 7-segment display.
// A sequential double-dabble engine converts the magnitude while the previous value stays on the display.
module signed_seg_display #(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic [1:0]        dbg_state
);

    localparam int MAGD = DIGITS - 1;
    localparam int BCDW = 4 * MAGD;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW   = $clog2(DIGITS);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(MAGD);

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return 8'h81;
            4'd1: return 8'hCF;
            4'd2: return 8'h92;
            4'd3: return 8'h86;
            4'd4: return 8'hCC;
            4'd5: return 8'hA4;
            4'd6: return 8'hA0;
            4'd7: return 8'h8F;
            4'd8: return 8'h80;
            4'd9: return 8'h84;
            default: return 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q;
    logic              sign_q, ovf_q;
    logic [WIDTH-1:0]  mag_q;
    logic [BCDW-1:0]   bcd_q, bcd_adj;
    logic              disp_sign_q, disp_ovf_q;
    logic [BCDW-1:0]   disp_bcd_q;
    logic [PW-1:0]     presc_q;
    logic [IW-1:0]     idx_q;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [WIDTH-1:0]  mag_in;
    logic              accept;

    // Valid/ready: a value is taken on any cycle where in_valid and in_ready are both high;
    // in_ready is high only in IDLE, so in_valid at any other time is simply not observed.
    assign accept = in_valid && in_ready;
    // Negating the most negative value wraps back to 2^(WIDTH-1), which is exact as unsigned.
    assign mag_in = in_value[WIDTH-1] ? (~in_value + WIDTH'(1)) : in_value;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CONV;
            S_CONV:  if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_CONV) || (state_q == S_LOAD);
        dbg_state = state_q;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < MAGD; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            disp_sign_q <= 1'b0;
            disp_ovf_q  <= 1'b0;
            disp_bcd_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    sign_q <= in_value[WIDTH-1];
                    mag_q  <= mag_in;
                    ovf_q  <= (64'(mag_in) >= LIMIT);
                    bcd_q  <= '0;
                    cnt_q  <= '0;
                end
                S_CONV: begin
                    bcd_q <= {bcd_adj[BCDW-2:0], mag_q[WIDTH-1]};
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q + CNTW'(1);
                end
                S_LOAD: begin
                    disp_sign_q <= sign_q;
                    disp_ovf_q  <= ovf_q;
                    disp_bcd_q  <= bcd_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    logic [3:0]      cur_digit;
    logic            cur_blank;
    logic            nz_seen;
    logic [MAGD-1:0] blank_vec;

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        nz_seen   = 1'b0;
        blank_vec = '0;
        // Walk from the most significant digit down; zeros before the first nonzero one are leading.
        for (int k = MAGD - 1; k >= 0; k--) begin
            nz_seen      = nz_seen | (disp_bcd_q[4*k +: 4] != 4'd0);
            blank_vec[k] = !nz_seen && (k != 0);
        end
        for (int k = 0; k < MAGD; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = disp_bcd_q[4*k +: 4];
                cur_blank = blank_vec[k];
            end
        end
        an_d = ~(DIGITS'(1) << idx_q);
        if (idx_q == IW'(DIGITS - 1))               seg_d = disp_sign_q ? 8'hFE : 8'hFF;
        else if (disp_ovf_q)                        seg_d = 8'hFE;
        else if ((BLANK_LEADING != 0) && cur_blank) seg_d = 8'hFF;
        else                                        seg_d = seg_decode(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign overflow = disp_ovf_q;

endmodule
